// File: rtl/timer_pkg.sv
// Shared constants and BCD time helpers for the HH:MM:SS scan timer.
// Time words are packed {h10,h01,m10,m01,s10,s01}, one BCD nibble each.
package timer_pkg;

    localparam logic [3:0] UNIT_MAX   = 4'd9;
    localparam logic [3:0] TENS_MAX   = 4'd5;
    localparam int         HOUR_LIMIT = 23;
    localparam logic [7:0] HOUR_LAST_BCD = {4'(HOUR_LIMIT / 10), 4'(HOUR_LIMIT % 10)};

    typedef enum logic [2:0] {
        FLD_S01 = 3'd0,
        FLD_S10 = 3'd1,
        FLD_M01 = 3'd2,
        FLD_M10 = 3'd3,
        FLD_H01 = 3'd4,
        FLD_H10 = 3'd5
    } field_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_CODE [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Nibbles 0..3 alternate units (0-9) and tens (0-5) of seconds and minutes.
    function automatic logic [3:0] field_max(input int i);
        return (i % 2 == 1) ? TENS_MAX : UNIT_MAX;
    endfunction

    function automatic int hours_value(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [23:0] hms_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == field_max(i)) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            if (r[23:16] == HOUR_LAST_BCD) begin
                r[23:16] = 8'h00;
            end else if (r[19:16] == UNIT_MAX) begin
                r[19:16] = 4'd0;
                r[23:20] = r[23:20] + 4'd1;
            end else begin
                r[19:16] = r[19:16] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] hms_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = field_max(i);
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        if (borrow) begin
            if (r[23:16] == 8'h00) begin
                r[23:16] = HOUR_LAST_BCD;
            end else if (r[19:16] == 4'd0) begin
                r[19:16] = UNIT_MAX;
                r[23:20] = r[23:20] - 4'd1;
            end else begin
                r[19:16] = r[19:16] - 4'd1;
            end
        end
        return r;
    endfunction

    // Out-of-range minute/second nibbles become 0; any invalid hour pair becomes 00.
    function automatic logic [23:0] hms_sanitize(input logic [23:0] v);
        logic [23:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > field_max(i)) begin
                r[i*4 +: 4] = 4'd0;
            end
        end
        if (v[19:16] > UNIT_MAX || hours_value(v[23:16]) > HOUR_LIMIT) begin
            r[23:16] = 8'h00;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment code; non-BCD input blanks.
module seg7_decode
    import timer_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (bcd_i <= UNIT_MAX) begin
            seg_n_o = SEG_CODE[bcd_i];
        end
    end

endmodule

// File: rtl/hms_scan_timer.sv
// 24-hour BCD clock/timer with multiplexed 7-segment scan output.
// Define HMS_TIMER_COUNTDOWN_EN to enable down-counting with an expired flag.
module hms_scan_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_DIV   = CLK_HZ,
    parameter int SCAN_DIV   = 5000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  load,
    input  logic [23:0]           load_value,
    input  logic                  down,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] digit,
    output logic                  tick,
    output logic                  expired
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam int              SW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0]   SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [2:0]      FIELD_BASE = (NUM_DIGITS == 6) ? 3'd0 : 3'd2;

    logic [PW-1:0]         presc_q, presc_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [2:0]            idx_q, idx_d;
    logic [23:0]           time_q, time_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;
    logic                  presc_wrap, hold_count, step;
    field_e                field;
    logic [3:0]            field_bcd;
    logic [7:0]            field_seg_n;
    logic [31:0]           unused_clk_hz;

    assign unused_clk_hz = CLK_HZ;

`ifdef HMS_TIMER_COUNTDOWN_EN
    logic expired_q, expired_d;
    logic time_zero;
`else
    logic unused_down;
    assign unused_down = down;
`endif

    always_comb begin
        presc_wrap = run && (presc_q == PRESC_LAST);
`ifdef HMS_TIMER_COUNTDOWN_EN
        time_zero  = (time_q == 24'h0);
        hold_count = expired_q || (down && time_zero);
`else
        hold_count = 1'b0;
`endif
        // A load in the same cycle swallows the tick entirely.
        step = presc_wrap && !load && !hold_count;
        tick = step && !reset;

        presc_d = presc_q;
        if (load || presc_wrap) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = presc_q + 1'b1;
        end

        time_d = time_q;
        if (load) begin
            time_d = hms_sanitize(load_value);
        end else if (step) begin
`ifdef HMS_TIMER_COUNTDOWN_EN
            time_d = down ? hms_dec(time_q) : hms_inc(time_q);
`else
            time_d = hms_inc(time_q);
`endif
        end

`ifdef HMS_TIMER_COUNTDOWN_EN
        expired_d = expired_q;
        if (load) begin
            expired_d = 1'b0;
        end else if (down && ((presc_wrap && time_zero) || (step && time_d == 24'h0))) begin
            expired_d = 1'b1;
        end
`endif
    end

    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    assign field     = field_e'(idx_q + FIELD_BASE);
    assign field_bcd = time_q[{field, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .bcd_i   (field_bcd),
        .seg_n_o (field_seg_n)
    );

    always_comb begin
        seg_d = field_seg_n;
        // Colon blink rides on the hour-units decimal point.
        if (field == FLD_H01 && presc_q < PRESC_HALF) begin
            seg_d[7] = 1'b0;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_d[gi] = (idx_q == 3'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            time_q  <= '0;
            seg_q   <= SEG_CODE[0];
            digit_q <= NUM_DIGITS'(1);
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            time_q  <= time_d;
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

`ifdef HMS_TIMER_COUNTDOWN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            expired_q <= 1'b0;
        end else begin
            expired_q <= expired_d;
        end
    end
    assign expired = expired_q;
`else
    assign expired = 1'b0;
`endif

    assign seg_n = seg_q;
    assign digit = digit_q;

endmodule
